// File: rtl/ti_share_encoder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ti_share_encoder_if : handshake bundle for the TI masking front end
// Rev 1.0
// ----------------------------------------------------------------------------
interface ti_share_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        reseed;
    logic [15:0] seed_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_shares;
    logic [15:0] xfer_count;

    modport master (
        output in_valid, in_data, reseed, seed_in, out_ready,
        input  in_ready, out_valid, out_shares, xfer_count
    );

    modport slave (
        input  in_valid, in_data, reseed, seed_in, out_ready,
        output in_ready, out_valid, out_shares, xfer_count
    );
endinterface
`default_nettype wire

// File: rtl/ti_share_encoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ti_share_encoder : splits nibbles into two Boolean shares with an LFSR mask
// Rev 1.0
// ----------------------------------------------------------------------------
module ti_share_encoder #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    ti_share_encoder_if.slave bus
);

    function automatic logic [15:0] f_lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    logic [15:0] r_lfsr;
    logic [7:0]  r_mem [2];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;
    logic [15:0] r_xfer;

    logic        w_push;
    logic        w_pop;
    logic [3:0]  w_mask;
    logic [15:0] w_lfsr_adv;

    assign bus.in_ready   = (r_count != 2'd2);
    assign bus.out_valid  = (r_count != 2'd0);
    assign bus.out_shares = r_mem[r_rptr];
    assign bus.xfer_count = r_xfer;

    assign w_push     = bus.in_valid && bus.in_ready;
    assign w_pop      = bus.out_valid && bus.out_ready;
    assign w_mask     = r_lfsr[3:0];
    // Four steps per accept so successive masks are disjoint windows of the stream.
    assign w_lfsr_adv = f_lfsr_step(f_lfsr_step(f_lfsr_step(f_lfsr_step(r_lfsr))));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr   <= SEED;
            r_mem[0] <= 8'h00;
            r_mem[1] <= 8'h00;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
            r_xfer   <= 16'h0000;
        end else begin
            if (bus.reseed) begin
                r_lfsr <= (bus.seed_in == 16'h0000) ? SEED : bus.seed_in;
            end else if (w_push) begin
                r_lfsr <= w_lfsr_adv;
            end

            if (w_push) begin
                r_mem[r_wptr] <= {w_mask, bus.in_data ^ w_mask};
                r_wptr        <= ~r_wptr;
            end

            if (w_pop) begin
                r_rptr <= ~r_rptr;
                r_xfer <= r_xfer + 16'd1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ti_share_encoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ti_share_encoder : scoreboard bench for ti_share_encoder
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ti_share_encoder;

    localparam logic [15:0] C_SEED = 16'hACE1;

    logic clk;
    logic rst;

    ti_share_encoder_if bus ();

    ti_share_encoder #(.SEED(C_SEED)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [11:0] sb [$];        // {nibble, share1, share0}
    logic [15:0] m_lfsr;
    logic [15:0] m_xfer;
    int          m_count;
    logic        prev_stall;
    logic [7:0]  prev_shares;
    logic [7:0]  hold;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] l);
        logic fb;
        fb = l[15] ^ l[13] ^ l[12] ^ l[10];
        return (l << 1) | {15'd0, fb};
    endfunction

    task automatic model_reset();
        sb.delete();
        m_lfsr     = C_SEED;
        m_xfer     = 16'h0000;
        m_count    = 0;
        prev_stall = 1'b0;
        prev_shares = 8'h00;
    endtask

    task automatic step();
        logic       push;
        logic       pop;
        logic [3:0] mask;
        logic [11:0] e;
        @(negedge clk);
        if (prev_stall) check("stall_hold", {24'd0, bus.out_shares}, {24'd0, prev_shares});
        check("xfer", {16'd0, bus.xfer_count}, {16'd0, m_xfer});
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, m_count != 2});
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_count != 0});
        push = bus.in_valid && (m_count != 2);
        pop  = bus.out_ready && (m_count != 0);
        mask = m_lfsr[3:0];
        if (push) sb.push_back({bus.in_data, mask, bus.in_data ^ mask});
        if (pop) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("shares", {24'd0, bus.out_shares}, {24'd0, e[7:0]});
                check("recomb", {28'd0, bus.out_shares[7:4] ^ bus.out_shares[3:0]}, {28'd0, e[11:8]});
            end
            m_xfer = m_xfer + 16'd1;
        end
        if (bus.reseed) m_lfsr = (bus.seed_in == 16'h0000) ? C_SEED : bus.seed_in;
        else if (push) m_lfsr = ref_step(ref_step(ref_step(ref_step(m_lfsr))));
        m_count = m_count + (push ? 1 : 0) - (pop ? 1 : 0);
        prev_stall  = bus.out_valid && !bus.out_ready;
        prev_shares = bus.out_shares;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #12;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'h0;
        bus.reseed    = 1'b0;
        bus.seed_in   = 16'h0000;
        bus.out_ready = 1'b0;
        model_reset();
        do_reset();

        // Reset state
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_shares", {24'd0, bus.out_shares}, 32'h00);
        check("rst_xfer", {16'd0, bus.xfer_count}, 32'd0);

        // Single transfer: A masked with SEED[3:0]=1
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'hA;
        step();
        bus.in_valid = 1'b0;
        check("single_valid", {31'd0, bus.out_valid}, 32'd1);
        check("single_shares", {24'd0, bus.out_shares}, 32'h1B);
        step();
        check("single_xfer", {16'd0, bus.xfer_count}, 32'd1);

        // Back-pressure fill
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'h3; step();
        bus.in_data   = 4'h5; step();
        check("bp_full", {31'd0, bus.in_ready}, 32'd0);
        hold = bus.out_shares;
        bus.in_data   = 4'h7; step();
        step();
        check("bp_hold", {24'd0, bus.out_shares}, {24'd0, hold});
        bus.out_ready = 1'b1;
        step();
        step();
        bus.in_valid = 1'b0;
        step();
        step();

        // Mask freshness: zero data exposes mask in both shares
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h0;
        for (int i = 0; i < 16; i++) begin
            step();
            check("fresh_eq", {28'd0, bus.out_shares[7:4]}, {28'd0, bus.out_shares[3:0]});
        end
        bus.in_valid = 1'b0;
        step();

        // Reseed with zero seed alongside an accept
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h6;
        bus.reseed   = 1'b1;
        bus.seed_in  = 16'h0000;
        step();
        bus.reseed   = 1'b0;
        step();
        check("reseed0_mask", {28'd0, bus.out_shares[7:4]}, 32'h1);
        bus.in_valid = 1'b0;
        bus.reseed   = 1'b1;
        bus.seed_in  = 16'h1234;
        step();
        bus.reseed   = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h9;
        step();
        check("reseed_mask", {28'd0, bus.out_shares[7:4]}, 32'h4);
        bus.in_valid = 1'b0;
        step();

        // Counter wrap after 65537 transfers
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'hC;
        for (int i = 0; i < 65537; i++) step();
        bus.in_valid = 1'b0;
        step();
        check("wrap_xfer", {16'd0, bus.xfer_count}, 32'd1);

        // Async reset with a full buffer
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'h2; step();
        bus.in_data   = 4'hE; step();
        check("pre_rst_full", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("arst_shares", {24'd0, bus.out_shares}, 32'h00);
        check("arst_xfer", {16'd0, bus.xfer_count}, 32'd0);
        #1;
        rst = 1'b0;
        model_reset();
        bus.out_ready = 1'b1;
        bus.in_data   = 4'h0;
        step();
        bus.in_valid = 1'b0;
        check("arst_mask", {24'd0, bus.out_shares}, 32'h11);
        step();
        check("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
